pulse_gen: RTL
==============

# pulse_gen

Transmit-side generator for the timer/register measurement interface. On each start request it drives a `timer` pulse exactly `len` clock cycles wide, holds `timer` low for a fixed gap, then issues a one-cycle `register` strobe so the downstream measurement block can latch its count. It sits upstream of the pulse-width measurement block and serves as an on-chip stimulus source and self-test driver.

## Interface
- `WIDTH`, 20: width of the pulse-length value and of the internal counter. It matches the 20-bit measurement path.
- `GAP`, 10: number of cycles `timer` is held low between the falling edge and the `register` strobe. Legal range is ≥1.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a transfer. Sampled only in IDLE.
- `len` input WIDTH: pulse length in cycles. Latched when `start` is accepted.
- `abort` input 1: cancels an in-flight transfer.
- `repeat` input 1: auto-restart request. Used only when `PULSE_GEN_REPEAT_EN` is defined; otherwise ignored.
- `timer` output 1: generated pulse.
- `register` output 1: one-cycle latch strobe.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle completion flag, coincident with `register`.

## Operation
- States:
  - IDLE
  - PULSE
  - GAP
  - STROBE
- State register, counter and all outputs are flops. There is no combinational path from inputs to outputs.
- Reset values:
  - state = IDLE
  - counter = 0
  - latched length = 0
  - `timer` = 0, `register` = 0, `busy` = 0, `done` = 0
- IDLE:
  - `start`=1 latches `len`.
  - If `len`≠0: go to PULSE and load counter with `len`−1.
  - If `len`=0: go directly to GAP and load counter with `GAP`−1. `timer` never rises.
- PULSE:
  - `timer`=1.
  - When counter=0: go to GAP and load `GAP`−1. Otherwise decrement.
- GAP:
  - `timer`=0.
  - When counter=0: go to STROBE. Otherwise decrement.
- STROBE:
  - `register`=1 and `done`=1 for exactly one cycle.
  - Then go to IDLE.
- `busy`=1 in PULSE, GAP and STROBE.
- `start` outside IDLE is ignored, not queued. Changes to `len` after acceptance have no effect.
- `abort`:
  - Sampled in PULSE or GAP: next state is IDLE and `timer` goes low next cycle. No `register` strobe and no `done`.
  - In STROBE: has no effect, and the strobe completes.
  - In IDLE: `abort` takes priority over `start`, so no transfer is started.
- Counter arithmetic is unsigned WIDTH-bit. `len`=2^WIDTH−1 is legal, and there is no wrap during a transfer.
- `rst` mid-transfer: all outputs drop immediately (asynchronously) to their reset values, and no strobe is emitted.

## Timing
- `start` sampled high at edge k with `len`=N≥1:
  - `timer` is high for cycles k+1 … k+N.
  - `timer` is low for cycles k+N+1 … k+N+GAP.
  - `register` and `done` are high in cycle k+N+GAP+1.
  - `busy` is high for cycles k+1 … k+N+GAP+1.
  - The earliest next `start` is accepted at edge k+N+GAP+1, so its first `timer` cycle is k+N+GAP+2.
- `len`=0: `register` fires in cycle k+GAP+1.
- Latency from `start` to the rising edge of `timer` is 1 cycle.
- The interval from the falling edge of `timer` to `register` is GAP cycles.

## Configuration
- `PULSE_GEN_REPEAT_EN` defined:
  - In STROBE, if `repeat`=1 and `abort`=0, the next state is PULSE, reloaded with the previously latched length (or GAP if that length was 0).
  - `busy` stays high across the restart.
  - The new `timer` pulse starts in the cycle immediately after the strobe.
- `PULSE_GEN_REPEAT_EN` undefined:
  - `repeat` is unused and STROBE always returns to IDLE.
  - Behaviour is identical to the macro-defined build with `repeat`=0.

## Test plan
- Reset release, then `start` with `len`=100 and GAP=10:
  - `timer` is high for exactly 100 cycles beginning 1 cycle after `start`.
  - `register` and `done` pulse once, 111 cycles after `start`.
  - `busy` is high for 111 cycles.
- `len`=0:
  - `timer` stays 0 throughout.
  - `register` fires 11 cycles after `start`.
- Back-to-back transfers:
  - `start` held high continuously with `len`=200, then 100.
  - The second transfer begins one cycle after the first strobe.
  - The `len` changes made while `busy` are ignored.
- `abort` at cycle 50 of a `len`=100 pulse:
  - `timer` is low next cycle.
  - No `register` or `done`, and `busy` returns to 0.
  - `abort` asserted during STROBE still lets the strobe complete.
- `rst` asserted mid-GAP, asynchronously between edges:
  - All outputs go to 0 without waiting for a clock edge.
  - The next `start` after reset behaves normally.
- With `PULSE_GEN_REPEAT_EN` defined and `repeat`=1, `len`=5:
  - `timer` high 5 cycles, low 10, strobe, repeating with a period of 16 cycles.
  - Dropping `repeat` ends the sequence after the current strobe.

Source files
------------

// File: rtl/pulse_gen.sv
// Timer-pulse / register-strobe generator: timer high for len cycles, GAP cycles low, then a one-cycle strobe.
// Optional auto-restart from the STROBE state when PULSE_GEN_REPEAT_EN is defined; repeat_req is the restart request.
module pulse_gen #(
    parameter int WIDTH = 20,
    parameter int GAP   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] len,
    input  logic             abort,
    input  logic             repeat_req,
    output logic             timer,
    output logic             register,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_STROBE
    } state_t;

    localparam logic [WIDTH-1:0] GAP_LOAD = WIDTH'(GAP - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        load     = 1'b0;
        load_val = len;

        unique case (state_q)
            ST_IDLE: begin
                load = start && !abort;
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_STROBE: begin
                // The strobe cycle doubles as an idle slot, so a waiting start begins right after it.
                state_d = ST_IDLE;
`ifdef PULSE_GEN_REPEAT_EN
                if (repeat_req && !abort) begin
                    load     = 1'b1;
                    load_val = len_q;
                end else begin
                    load = start && !abort;
                end
`else
                load = start && !abort;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            len_d = load_val;
            if (load_val != '0) begin
                state_d = ST_PULSE;
                cnt_d   = load_val - ONE;
            end else begin
                state_d = ST_GAP;
                cnt_d   = GAP_LOAD;
            end
        end
    end

`ifndef PULSE_GEN_REPEAT_EN
    logic unused_cfg;
    assign unused_cfg = repeat_req ^ (^len_q);
`endif

    // Outputs are registered from the next state, giving one-cycle start-to-timer latency with no comb path.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            timer    <= 1'b0;
            register <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            timer    <= (state_d == ST_PULSE);
            register <= (state_d == ST_STROBE);
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_STROBE);
        end
    end

endmodule
